// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and default sizing for the UART transmit arbiter.
package uart_arb_pkg;

  // Arbiter FSM: pick a requester, fire the transmitter, wait for completion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker. Returns the first set bit
// of req_i at or above ptr_i, wrapping modulo NUM_REQ, plus an any-set flag.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  localparam int IDW     = $clog2(NUM_REQ),
  localparam int SW      = IDW + 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [IDW-1:0]     idx_o,
  output logic               any_o
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SW-1:0]        sum;

  // Rotate the request vector so bit 0 is the requester at the pointer.
  assign dbl = {req_i, req_i};
  assign rot = dbl[ptr_i +: NUM_REQ];

  // Scan from the far end so the lowest rotated offset is the last to win.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr_i} + SW'(k);
        if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
        idx_o = sum[IDW-1:0];
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that hands single bytes from NUM_REQ
// requesters to one 8N1 transmitter and aborts a frame whose txdone never
// arrives within TIMEOUT_CYCLES. Define UART_ARB_LOCK_EN to compile in the
// frame-lock feature (a requester may hold the grant across several bytes).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int  NUM_REQ        = DEF_NUM_REQ,
  parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int IDW            = $clog2(NUM_REQ),
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_byte,
  output logic                 tx_send,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 timeout_err
);

  arb_state_e         state_q;
  logic [IDW-1:0]     rr_ptr_q;
  logic [IDW-1:0]     grant_id_q;
  logic [7:0]         tx_byte_q;
  logic               tx_send_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic               busy_q;
  logic               timeout_err_q;
  logic [CNT_W-1:0]   wait_cnt_q;

  logic [NUM_REQ-1:0] elig_d;
  logic [NUM_REQ-1:0] grant_oh_d;
  logic [7:0]         sel_byte_d;
  logic [IDW-1:0]     rr_ptr_d;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;

`ifdef UART_ARB_LOCK_EN
  logic               lock_vld_q;
  logic [IDW-1:0]     lock_owner_q;
  logic [NUM_REQ-1:0] owner_oh;
  logic               lock_hold;

  // One-hot of the current lock owner, used to mask out everybody else.
  always_comb begin
    owner_oh = '0;
    for (int k = 0; k < NUM_REQ; k++) owner_oh[k] = (lock_owner_q == IDW'(k));
  end

  assign lock_hold = lock_vld_q & req_lock[lock_owner_q];
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
`endif

  // Eligible requesters: all valid ones, or only the owner while it holds the lock.
  always_comb begin
    elig_d = req_valid;
`ifdef UART_ARB_LOCK_EN
    if (lock_hold) elig_d = req_valid & owner_oh;
`endif
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i (elig_d),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Winner's one-hot ready pattern and its data byte.
  always_comb begin
    grant_oh_d = '0;
    sel_byte_d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == IDW'(k)) begin
        grant_oh_d[k] = 1'b1;
        sel_byte_d    = req_data[k*8 +: 8];
      end
    end
  end

  // Pointer after a finished or aborted frame: one past the granted requester.
  assign rr_ptr_d = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  // Arbiter FSM with registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      tx_byte_q     <= '0;
      tx_send_q     <= 1'b0;
      req_ready_q   <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      wait_cnt_q    <= '0;
`ifdef UART_ARB_LOCK_EN
      lock_vld_q    <= 1'b0;
      lock_owner_q  <= '0;
`endif
    end else begin
      tx_send_q     <= 1'b0;
      req_ready_q   <= '0;
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
`ifdef UART_ARB_LOCK_EN
          if (lock_vld_q && !req_lock[lock_owner_q]) lock_vld_q <= 1'b0;
`endif
          if (pick_any) begin
            grant_id_q  <= pick_idx;
            tx_byte_q   <= sel_byte_d;
            tx_send_q   <= 1'b1;
            req_ready_q <= grant_oh_d;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT;
`ifdef UART_ARB_LOCK_EN
          if (req_lock[grant_id_q]) begin
            lock_vld_q   <= 1'b1;
            lock_owner_q <= grant_id_q;
          end
`endif
        end
        WAIT: begin
          if (tx_done) begin
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rr_ptr_q      <= rr_ptr_d;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_byte     = tx_byte_q;
  assign tx_send     = tx_send_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

endmodule
